// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c bus-sharing logic: arbiter states and
// byte widths used on the requester and master sides.
package i2c_pkg;

    localparam int I2C_ADDR_W = 8;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANTED  = 2'd1,
        ACTIVE   = 2'd2,
        RELEASE  = 2'd3
    } state_t;

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: picks the first set request
// bit at or after pointer, wrapping past the top index back to zero.
module rr_pick #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] pointer,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] index,
    output logic           any
);

    int idx;

    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        idx    = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(pointer) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                onehot[idx] = 1'b1;
                index       = IDW'(idx);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin, transaction-atomic sharing of one i2c_master between several
// requesters; the owner's handshake is muxed through unchanged.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int GRANT_TIMEOUT  = 4800,
    parameter int ID_WIDTH       = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                               clk_in,
    input  logic                               reset,
    input  logic [NUM_REQUESTERS-1:0]          req,
    output logic [NUM_REQUESTERS-1:0]          grant,
    output logic [ID_WIDTH-1:0]                grant_id,
    input  logic [I2C_ADDR_W*NUM_REQUESTERS-1:0] r_address,
    input  logic [NUM_REQUESTERS-1:0]          r_transfer_start,
    input  logic [NUM_REQUESTERS-1:0]          r_transfer_continues,
    input  logic [I2C_DATA_W*NUM_REQUESTERS-1:0] r_data_tx,
    output logic [NUM_REQUESTERS-1:0]          r_transfer_ready,
    output logic [NUM_REQUESTERS-1:0]          r_interrupt,
    output logic [NUM_REQUESTERS-1:0]          r_transaction_complete,
    output logic                               r_nack,
    output logic                               r_address_err,
    output logic [I2C_DATA_W-1:0]              r_data_rx,
    output logic [I2C_ADDR_W-1:0]              m_address,
    output logic                               m_transfer_start,
    output logic                               m_transfer_continues,
    output logic [I2C_DATA_W-1:0]              m_data_tx,
    input  logic                               m_transfer_ready,
    input  logic                               m_interrupt,
    input  logic                               m_transaction_complete,
    input  logic                               m_nack,
    input  logic                               m_address_err,
    input  logic [I2C_DATA_W-1:0]              m_data_rx,
    input  logic                               m_bus_clear,
    output logic                               timeout_err
);

    localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);

    state_t                      state, state_next;
    logic [NUM_REQUESTERS-1:0]   grant_q, grant_next;
    logic [ID_WIDTH-1:0]         grant_id_q, grant_id_next;
    logic [ID_WIDTH-1:0]         pointer_q, pointer_next;
    logic [CNT_W-1:0]            count_q, count_next;

    logic [NUM_REQUESTERS-1:0]   pick_onehot;
    logic [ID_WIDTH-1:0]         pick_index;
    logic                        pick_any;

    logic [I2C_ADDR_W-1:0]       own_addr;
    logic [I2C_DATA_W-1:0]       own_data;
    logic                        own_req, own_start, own_cont, bus_owned;

    rr_pick #(
        .N   (NUM_REQUESTERS),
        .IDW (ID_WIDTH)
    ) u_pick (
        .req     (req),
        .pointer (pointer_q),
        .onehot  (pick_onehot),
        .index   (pick_index),
        .any     (pick_any)
    );

    // grant_q is one-hot (or zero), so OR-ing the masked lanes selects the owner.
    always_comb begin
        own_addr = '0;
        own_data = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant_q[i]) begin
                own_addr = own_addr | r_address[i*I2C_ADDR_W +: I2C_ADDR_W];
                own_data = own_data | r_data_tx[i*I2C_DATA_W +: I2C_DATA_W];
            end
        end
    end

    assign own_req   = |(req & grant_q);
    assign own_start = |(r_transfer_start & grant_q);
    assign own_cont  = |(r_transfer_continues & grant_q);
    assign bus_owned = (state == GRANTED) || (state == ACTIVE);

    // Handshake: a transfer_start is accepted by the master on any cycle where
    // both start and m_transfer_ready are high; start is held until then.
    assign m_address            = own_addr;
    assign m_data_tx            = own_data;
    assign m_transfer_start     = own_start & bus_owned & ~reset;
    assign m_transfer_continues = own_cont & bus_owned & ~reset;

    assign r_transfer_ready       = grant_q & {NUM_REQUESTERS{m_transfer_ready}};
    assign r_interrupt            = grant_q & {NUM_REQUESTERS{m_interrupt}};
    assign r_transaction_complete = grant_q & {NUM_REQUESTERS{m_transaction_complete}};
    assign r_nack                 = m_nack;
    assign r_address_err          = m_address_err;
    assign r_data_rx              = m_data_rx;

    assign grant    = grant_q;
    assign grant_id = grant_id_q;

    always_comb begin
        state_next    = state;
        grant_next    = grant_q;
        grant_id_next = grant_id_q;
        pointer_next  = pointer_q;
        count_next    = count_q;
        timeout_err   = 1'b0;
        case (state)
            IDLE: begin
                if (m_bus_clear && pick_any) begin
                    grant_next    = pick_onehot;
                    grant_id_next = pick_index;
                    count_next    = '0;
                    state_next    = GRANTED;
                end
            end
            GRANTED: begin
                if (own_start && m_transfer_ready) begin
                    state_next = ACTIVE;
                end else if (!own_req) begin
                    grant_next = '0;
                    state_next = RELEASE;
                end else if (count_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
                    timeout_err = 1'b1;
                    grant_next  = '0;
                    state_next  = RELEASE;
                end else begin
                    count_next = count_q + CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (m_transaction_complete || (m_interrupt && m_address_err)) begin
                    grant_next = '0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                // grant_id still names the outgoing owner here.
                pointer_next = (grant_id_q == ID_WIDTH'(NUM_REQUESTERS - 1)) ?
                               '0 : grant_id_q + ID_WIDTH'(1);
                count_next   = '0;
                state_next   = IDLE;
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            pointer_q  <= '0;
            count_q    <= '0;
        end else begin
            state      <= state_next;
            grant_q    <= grant_next;
            grant_id_q <= grant_id_next;
            pointer_q  <= pointer_next;
            count_q    <= count_next;
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: expected grant events, master handshakes and
// per-cycle signal checks are queued by the stimulus and compared at negedge.
module tb_i2c_arbiter;

    localparam int N   = 2;
    localparam int TMO = 16;

    localparam int S_GRANT  = 0;
    localparam int S_GID    = 1;
    localparam int S_TE     = 2;
    localparam int S_MSTART = 3;
    localparam int S_RREADY = 4;
    localparam int S_RINT   = 5;
    localparam int S_AERR   = 6;
    localparam int S_NACK   = 7;
    localparam int S_DRX    = 8;
    localparam int S_MADDR  = 9;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] want;
    } chk_t;

    logic           clk_in = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [0:0]     grant_id;
    logic [8*N-1:0] r_address;
    logic [N-1:0]   r_transfer_start;
    logic [N-1:0]   r_transfer_continues;
    logic [8*N-1:0] r_data_tx;
    logic [N-1:0]   r_transfer_ready;
    logic [N-1:0]   r_interrupt;
    logic [N-1:0]   r_transaction_complete;
    logic           r_nack;
    logic           r_address_err;
    logic [7:0]     r_data_rx;
    logic [7:0]     m_address;
    logic           m_transfer_start;
    logic           m_transfer_continues;
    logic [7:0]     m_data_tx;
    logic           m_transfer_ready;
    logic           m_interrupt;
    logic           m_transaction_complete;
    logic           m_nack;
    logic           m_address_err;
    logic [7:0]     m_data_rx;
    logic           m_bus_clear;
    logic           timeout_err;

    int         total = 0;
    int         bad   = 0;
    logic       done  = 1'b0;
    logic [2:0]  ev_exp_q[$];
    logic [16:0] xfer_exp_q[$];
    chk_t        chk_q[$];
    logic [2:0]  prev_ev = 3'b000;

    always #5 clk_in = ~clk_in;

    i2c_arbiter #(
        .NUM_REQUESTERS (N),
        .GRANT_TIMEOUT  (TMO),
        .ID_WIDTH       (1)
    ) dut (
        .clk_in                 (clk_in),
        .reset                  (reset),
        .req                    (req),
        .grant                  (grant),
        .grant_id               (grant_id),
        .r_address              (r_address),
        .r_transfer_start       (r_transfer_start),
        .r_transfer_continues   (r_transfer_continues),
        .r_data_tx              (r_data_tx),
        .r_transfer_ready       (r_transfer_ready),
        .r_interrupt            (r_interrupt),
        .r_transaction_complete (r_transaction_complete),
        .r_nack                 (r_nack),
        .r_address_err          (r_address_err),
        .r_data_rx              (r_data_rx),
        .m_address              (m_address),
        .m_transfer_start       (m_transfer_start),
        .m_transfer_continues   (m_transfer_continues),
        .m_data_tx              (m_data_tx),
        .m_transfer_ready       (m_transfer_ready),
        .m_interrupt            (m_interrupt),
        .m_transaction_complete (m_transaction_complete),
        .m_nack                 (m_nack),
        .m_address_err          (m_address_err),
        .m_data_rx              (m_data_rx),
        .m_bus_clear            (m_bus_clear),
        .timeout_err            (timeout_err)
    );

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_GRANT:  return 32'(grant);
            S_GID:    return 32'(grant_id);
            S_TE:     return 32'(timeout_err);
            S_MSTART: return 32'(m_transfer_start);
            S_RREADY: return 32'(r_transfer_ready);
            S_RINT:   return 32'(r_interrupt);
            S_AERR:   return 32'(r_address_err);
            S_NACK:   return 32'(r_nack);
            S_DRX:    return 32'(r_data_rx);
            S_MADDR:  return 32'(m_address);
            default:  return 32'hdead_beef;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input int sel, input logic [31:0] want);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.want = want;
        chk_q.push_back(c);
    endtask

    task automatic byte_xfer(input int idx, input logic [7:0] addr, input logic [7:0] data,
                             input logic cont);
        r_data_tx[idx*8 +: 8]      = data;
        r_transfer_continues[idx]  = cont;
        r_transfer_start[idx]      = 1'b1;
        xfer_exp_q.push_back({cont, addr, data});
        tick();
        r_transfer_start[idx]      = 1'b0;
        r_transfer_continues[idx]  = 1'b0;
    endtask

    task automatic finish_txn(input int idx, input logic drop);
        m_transaction_complete = 1'b1;
        if (drop) req[idx] = 1'b0;
        tick();
        m_transaction_complete = 1'b0;
    endtask

    // Scoreboard / monitor: sole owner of the counters.
    always @(negedge clk_in) begin : sb
        logic [2:0]  ev;
        logic [2:0]  ev_want;
        logic [16:0] xf;
        logic [16:0] xf_want;
        logic [31:0] got;
        chk_t        c;
        ev = {timeout_err, grant};
        if (ev != prev_ev) begin
            total++;
            if (ev_exp_q.size() == 0) begin
                bad++;
                $display("FAIL grant_event: got=%b want=none", ev);
            end else begin
                ev_want = ev_exp_q.pop_front();
                if (ev !== ev_want) begin
                    bad++;
                    $display("FAIL grant_event: got=%b want=%b", ev, ev_want);
                end
            end
        end
        prev_ev = ev;
        if (m_transfer_start && m_transfer_ready) begin
            xf = {m_transfer_continues, m_address, m_data_tx};
            total++;
            if (xfer_exp_q.size() == 0) begin
                bad++;
                $display("FAIL master_handshake: got=%h want=none", xf);
            end else begin
                xf_want = xfer_exp_q.pop_front();
                if (xf !== xf_want) begin
                    bad++;
                    $display("FAIL master_handshake: got=%h want=%h", xf, xf_want);
                end
            end
        end
        while (chk_q.size() > 0) begin
            c   = chk_q.pop_front();
            got = sample(c.sel);
            total++;
            if (got !== c.want) begin
                bad++;
                $display("FAIL %s: got=%0h want=%0h", c.name, got, c.want);
            end
        end
        if (done) begin
            total++;
            if (ev_exp_q.size() != 0) begin
                bad++;
                $display("FAIL grant_events_left: got=%0d want=0", ev_exp_q.size());
            end
            total++;
            if (xfer_exp_q.size() != 0) begin
                bad++;
                $display("FAIL handshakes_left: got=%0d want=0", xfer_exp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=no_finish want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset                  = 1'b1;
        req                    = '0;
        r_address              = {8'h48, 8'h20};
        r_transfer_start       = '0;
        r_transfer_continues   = '0;
        r_data_tx              = '0;
        m_transfer_ready       = 1'b1;
        m_interrupt            = 1'b0;
        m_transaction_complete = 1'b0;
        m_nack                 = 1'b0;
        m_address_err          = 1'b0;
        m_data_rx              = 8'h00;
        m_bus_clear            = 1'b1;
        tick();
        tick();
        check("rst_grant", S_GRANT, 0);
        check("rst_gid", S_GID, 0);
        check("rst_timeout", S_TE, 0);
        check("rst_mstart", S_MSTART, 0);
        reset = 1'b0;

        // Contention from pointer 0: requester 0 then 1, with a two-cycle gap.
        req = 2'b11;
        ev_exp_q.push_back(3'b001);
        tick();
        check("a_grant0", S_GRANT, 1);
        check("a_gid0", S_GID, 0);
        check("a_rready0", S_RREADY, 1);
        byte_xfer(0, 8'h20, 8'h11, 1'b0);
        ev_exp_q.push_back(3'b000);
        ev_exp_q.push_back(3'b010);
        finish_txn(0, 1'b1);
        check("a_release", S_GRANT, 0);
        tick();
        check("a_idle_gap", S_GRANT, 0);
        tick();
        check("a_grant1", S_GRANT, 2);
        check("a_gid1", S_GID, 1);
        check("a_rready1", S_RREADY, 2);
        byte_xfer(1, 8'h48, 8'h22, 1'b0);
        ev_exp_q.push_back(3'b000);
        finish_txn(1, 1'b1);
        tick();
        tick();

        // Single requester, two-byte write to 0x20.
        req = 2'b01;
        ev_exp_q.push_back(3'b001);
        tick();
        check("s_grant", S_GRANT, 1);
        check("s_maddr", S_MADDR, 32'h20);
        byte_xfer(0, 8'h20, 8'hA1, 1'b1);
        m_transfer_ready = 1'b0;
        tick();
        tick();
        m_transfer_ready = 1'b1;
        byte_xfer(0, 8'h20, 8'hB2, 1'b0);
        m_transfer_ready = 1'b0;
        tick();
        ev_exp_q.push_back(3'b000);
        finish_txn(0, 1'b1);
        m_transfer_ready = 1'b1;
        check("s_release_grant", S_GRANT, 0);
        r_transfer_start[0] = 1'b1;
        #1;
        check("s_release_mstart", S_MSTART, 0);
        tick();
        r_transfer_start[0] = 1'b0;
        check("s_idle_grant", S_GRANT, 0);

        // Pointer now 1: both requesting serves 1 then 0.
        req = 2'b11;
        ev_exp_q.push_back(3'b010);
        tick();
        check("b_grant1", S_GRANT, 2);
        check("b_gid1", S_GID, 1);
        byte_xfer(1, 8'h48, 8'h33, 1'b0);
        ev_exp_q.push_back(3'b000);
        ev_exp_q.push_back(3'b001);
        finish_txn(1, 1'b1);
        tick();
        tick();
        check("b_grant0", S_GRANT, 1);

        // Atomicity: owner 0 drops req while ACTIVE.
        req = 2'b11;
        byte_xfer(0, 8'h20, 8'h44, 1'b1);
        req = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t_hold_grant", S_GRANT, 1);
            check("t_rready_owner_only", S_RREADY, 1);
        end
        ev_exp_q.push_back(3'b000);
        ev_exp_q.push_back(3'b010);
        finish_txn(0, 1'b0);
        tick();
        tick();
        check("t_next_grant", S_GRANT, 2);

        // Address error ends the transaction.
        byte_xfer(1, 8'h48, 8'h55, 1'b0);
        m_interrupt   = 1'b1;
        m_address_err = 1'b1;
        #1;
        check("e_addr_err", S_AERR, 1);
        check("e_interrupt", S_RINT, 2);
        ev_exp_q.push_back(3'b000);
        req = 2'b00;
        tick();
        m_interrupt   = 1'b0;
        m_address_err = 1'b0;
        check("e_release", S_GRANT, 0);
        m_nack    = 1'b1;
        m_data_rx = 8'h5A;
        #1;
        check("p_nack", S_NACK, 1);
        check("p_data_rx", S_DRX, 32'h5A);
        tick();
        m_nack    = 1'b0;
        m_data_rx = 8'h00;
        tick();

        // Timeout: requester 0 never starts, requester 1 waits.
        req = 2'b11;
        ev_exp_q.push_back(3'b001);
        ev_exp_q.push_back(3'b101);
        ev_exp_q.push_back(3'b000);
        ev_exp_q.push_back(3'b010);
        tick();
        for (int k = 1; k <= TMO; k++) begin
            check("o_pulse", S_TE, 32'(k == TMO));
            if (k < TMO) tick();
        end
        tick();
        check("o_release", S_GRANT, 0);
        check("o_pulse_end", S_TE, 0);
        tick();
        tick();
        check("o_next_grant", S_GRANT, 2);
        ev_exp_q.push_back(3'b000);
        req = 2'b00;
        tick();
        check("o_drop_release", S_GRANT, 0);
        check("o_drop_no_pulse", S_TE, 0);
        tick();
        tick();

        // Bus busy blocks the grant.
        m_bus_clear = 1'b0;
        req = 2'b01;
        tick();
        check("u_busy0", S_GRANT, 0);
        tick();
        check("u_busy1", S_GRANT, 0);
        ev_exp_q.push_back(3'b001);
        m_bus_clear = 1'b1;
        tick();
        check("u_grant", S_GRANT, 1);
        byte_xfer(0, 8'h20, 8'h66, 1'b0);
        ev_exp_q.push_back(3'b000);
        finish_txn(0, 1'b1);
        tick();
        tick();

        // Reset in ACTIVE with pointer at 1.
        req = 2'b11;
        ev_exp_q.push_back(3'b010);
        tick();
        check("r_grant1", S_GRANT, 2);
        byte_xfer(1, 8'h48, 8'h77, 1'b0);
        reset = 1'b1;
        r_transfer_start[1] = 1'b1;
        ev_exp_q.push_back(3'b000);
        #1;
        check("r_mstart_forced", S_MSTART, 0);
        tick();
        r_transfer_start[1] = 1'b0;
        check("r_grant_drop", S_GRANT, 0);
        check("r_gid_clear", S_GID, 0);
        reset = 1'b0;
        ev_exp_q.push_back(3'b001);
        tick();
        check("r_pointer_zero", S_GRANT, 1);
        ev_exp_q.push_back(3'b000);
        req = 2'b00;
        tick();
        check("r_final_release", S_GRANT, 0);
        tick();
        tick();
        done = 1'b1;
        tick();
    end

endmodule
